eval_stack: RTL and testbench
=============================

# eval_stack

Operand (evaluation) stack consumed by the bytecode control unit. It services one push or pop per trigger over the control unit's `evalpush`/`evaltrigger`/`evaldone` handshake. Data is held in a synchronous single-port RAM with a registered stack pointer. It flags overflow and underflow and exposes the current depth for debug and stack-trace logic.

## Interface
- `DEPTH`, default 64: number of 32-bit entries; power of two, ≥ 2.
- `WIDTH`, default 32: entry width in bits.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst`  in  1  reset; asynchronous, active-high.
- `evalpush`  in  1  operation select, sampled at trigger acceptance: 1 = push, 0 = pop.
- `evaltrigger`  in  1  request line; a 0→1 transition starts an operation.
- `evalwrite`  in  WIDTH  push data, sampled at trigger acceptance.
- `evalread`  out  WIDTH  popped value; valid while `evaldone`=1 and held until the next pop completes.
- `evaldone`  out  1  one-cycle completion pulse.
- `depth`  out  $clog2(DEPTH)+1  current number of entries, 0..DEPTH.
- `overflow`  out  1  sticky error flag: push attempted while full.
- `underflow`  out  1  sticky error flag: pop attempted while empty.

## Operation
- States: IDLE, PUSH_WR, POP_RD, POP_LATCH.
- Trigger detect: register `trig_q` <= `evaltrigger` every cycle. Accept when state=IDLE && `evaltrigger` && !`trig_q`.
  - A trigger held high for multiple cycles is one request.
  - A rising edge in any state other than IDLE is ignored and is not queued.
- On accept, capture `evalpush` and `evalwrite`. Transition to PUSH_WR (push) or POP_RD (pop).
- PUSH_WR:
  - If `depth` < DEPTH: write `mem[sp]`, `sp` <= `sp`+1.
  - If full: no write, `sp` unchanged, `overflow` <= 1.
  - Either way, assert `evaldone` and return to IDLE.
- POP_RD:
  - If `depth` > 0: `sp` <= `sp`−1 and issue RAM read at address `sp`−1. Go to POP_LATCH.
  - If empty: `underflow` <= 1, `evalread` <= 0, assert `evaldone`, return to IDLE.
- POP_LATCH: `evalread` <= RAM data, assert `evaldone`, return to IDLE.
- `sp` is $clog2(DEPTH)+1 bits wide, and `depth` = `sp`. Neither ever wraps: the guards above prevent it.
- `evalread` changes only when a pop completes. Pushes leave it untouched.
- Reset values: state=IDLE, `sp`=0, `trig_q`=0, `evaldone`=0, `evalread`=0, `overflow`=0, `underflow`=0. RAM contents are not reset.
- Reset mid-operation: the in-flight request is dropped, and no `evaldone` is emitted after reset deasserts.

## Timing
- Accepting edge is T0.
- Push: RAM write and `sp` update at T1. `evaldone`=1 for cycle T1–T2.
- Pop, non-empty: `sp` decrement and read address at T1; `evalread` registered at T2. `evaldone`=1 for cycle T2–T3.
- Pop, empty: `evaldone`=1 for cycle T1–T2, with `evalread`=0.
- `evaldone` is registered and high for exactly one cycle per accepted request.
- Earliest next accept is the edge where `evaldone` is sampled high. The requester may raise `evaltrigger` in the same cycle it sees `evaldone`; this is back-to-back pops with a 3-cycle period.
- `depth` reflects the `sp` register, so it updates at T1 for both push and pop.

## Configuration
- `EVAL_STACK_ERR_EN` defined:
  - `overflow`/`underflow` behave as above and are cleared only by `rst`.
- Not defined:
  - Both flags are tied to 0 and their registers are not synthesized.
  - Full/empty guards, `evaldone` timing and the `evalread`=0-on-empty behaviour are unchanged.

## Test plan
- Push 0x11, 0x22, 0x33 (one trigger pulse each), then pop ×3 → `evalread` = 0x33, 0x22, 0x11. `depth` goes 1,2,3,2,1,0. `evaldone` at T1 for pushes, T2 for pops.
- Pop after reset → `evalread`=0, `evaldone` at T1, `depth`=0, `underflow`=1 with `EVAL_STACK_ERR_EN`, 0 without.
- DEPTH=4: push 1..5 → `depth`=4, `overflow`=1 after the fifth push. Pop ×4 → 4,3,2,1.
- Hold `evaltrigger` high for 6 cycles with `evalpush`=1, data 0x7 → exactly one push, `depth`=1, one `evaldone` pulse.
- Pop-pop chain: retrigger in the `evaldone` cycle → second pop is accepted on that edge, both values correct, `evaldone` 3 cycles apart.
- Assert `rst` at T1 of a pop from depth 2 → after release: `depth`=0, `evalread`=0, no `evaldone` pulse, flags 0.

Source files
------------

// File: rtl/eval_stack.sv
// rtl/eval_stack.sv - operand stack serviced by a one-request-per-trigger push/pop handshake
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   evalpush        1 = push, 0 = pop (sampled at trigger acceptance)
//   evaltrigger     request line; a rising edge seen in IDLE starts one operation
//   evalwrite       push data (sampled at trigger acceptance)
//   evalread        last popped value, held until the next pop completes
//   evaldone        one-cycle completion pulse
//   depth           current number of entries, 0..DEPTH
//   overflow        sticky: push attempted while full
//   underflow       sticky: pop attempted while empty
// Optional feature: define EVAL_STACK_ERR_EN to build the sticky error flags;
// without it both flags are tied to 0.

module eval_stack #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   evalpush,
  input  logic                   evaltrigger,
  input  logic [WIDTH-1:0]       evalwrite,
  output logic [WIDTH-1:0]       evalread,
  output logic                   evaldone,
  output logic [$clog2(DEPTH):0] depth,
  output logic                   overflow,
  output logic                   underflow
);

  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = AW + 1;
  localparam logic [SPW-1:0] FULL_SP = SPW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PUSH_WR   = 2'd1,
    POP_RD    = 2'd2,
    POP_LATCH = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             trig_q, trig_d;
  logic [SPW-1:0]   sp_q, sp_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic [WIDTH-1:0] evalread_q, evalread_d;
  logic             evaldone_q, evaldone_d;
  logic [WIDTH-1:0] ram_rdata_q;

  logic             accept;
  logic             full;
  logic             empty;
  logic             mem_we;
  logic             mem_re;
  logic [AW-1:0]    ram_addr;

  logic [WIDTH-1:0] mem [DEPTH];

  // Only a rising edge observed while idle is a request; edges during an
  // operation are dropped rather than queued.
  assign trig_d = evaltrigger;
  assign accept = (state_q == IDLE) && evaltrigger && !trig_q;
  assign full   = (sp_q == FULL_SP);
  assign empty  = (sp_q == '0);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = evalpush ? PUSH_WR : POP_RD;
        end
      end
      PUSH_WR:   state_d = IDLE;
      POP_RD:    state_d = empty ? IDLE : POP_LATCH;
      POP_LATCH: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    sp_d       = sp_q;
    wdata_d    = wdata_q;
    evalread_d = evalread_q;
    evaldone_d = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    ram_addr   = sp_q[AW-1:0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          wdata_d = evalwrite;
        end
      end
      PUSH_WR: begin
        evaldone_d = 1'b1;
        if (!full) begin
          mem_we = 1'b1;
          sp_d   = sp_q + SPW'(1);
        end
      end
      POP_RD: begin
        if (!empty) begin
          // Low AW bits of sp-1 are the top-of-stack address even when sp == DEPTH.
          mem_re   = 1'b1;
          ram_addr = sp_q[AW-1:0] - AW'(1);
          sp_d     = sp_q - SPW'(1);
        end else begin
          evalread_d = '0;
          evaldone_d = 1'b1;
        end
      end
      POP_LATCH: begin
        evalread_d = ram_rdata_q;
        evaldone_d = 1'b1;
      end
      default: begin
        evaldone_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      trig_q     <= 1'b0;
      sp_q       <= '0;
      wdata_q    <= '0;
      evalread_q <= '0;
      evaldone_q <= 1'b0;
    end else begin
      trig_q     <= trig_d;
      sp_q       <= sp_d;
      wdata_q    <= wdata_d;
      evalread_q <= evalread_d;
      evaldone_q <= evaldone_d;
    end
  end

  // Single-port synchronous RAM; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[ram_addr] <= wdata_q;
    end else if (mem_re) begin
      ram_rdata_q <= mem[ram_addr];
    end
  end

`ifdef EVAL_STACK_ERR_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  always_comb begin
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if ((state_q == PUSH_WR) && full) begin
      overflow_d = 1'b1;
    end
    if ((state_q == POP_RD) && empty) begin
      underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

  assign evalread = evalread_q;
  assign evaldone = evaldone_q;
  assign depth    = sp_q;

endmodule

// File: tb/tb_eval_stack.sv
// tb/tb_eval_stack.sv - self-checking bench for eval_stack against a queue-based stack model
module tb_eval_stack;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;
  localparam int DW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             evalpush;
  logic             evaltrigger;
  logic [WIDTH-1:0] evalwrite;
  logic [WIDTH-1:0] evalread;
  logic             evaldone;
  logic [DW-1:0]    depth;
  logic             overflow;
  logic             underflow;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] stk [$];
  logic             ovf_m = 1'b0;
  logic             unf_m = 1'b0;
  logic [WIDTH-1:0] rd_m  = '0;

  eval_stack #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .evalpush    (evalpush),
    .evaltrigger (evaltrigger),
    .evalwrite   (evalwrite),
    .evalread    (evalread),
    .evaldone    (evaldone),
    .depth       (depth),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic exp_ovf();
`ifdef EVAL_STACK_ERR_EN
    return ovf_m;
`else
    return ovf_m & 1'b0;
`endif
  endfunction

  function automatic logic exp_unf();
`ifdef EVAL_STACK_ERR_EN
    return unf_m;
`else
    return unf_m & 1'b0;
`endif
  endfunction

  // Stack semantics: LIFO, bounded at DEPTH, errors are sticky.
  task automatic model_op(input logic p, input logic [WIDTH-1:0] d, output int lat);
    if (p) begin
      lat = 1;
      if (stk.size() < DEPTH) stk.push_back(d);
      else ovf_m = 1'b1;
    end else if (stk.size() > 0) begin
      lat = 2;
      rd_m = stk.pop_back();
    end else begin
      lat = 1;
      rd_m = '0;
      unf_m = 1'b1;
    end
  endtask

  task automatic model_reset();
    stk.delete();
    ovf_m = 1'b0;
    unf_m = 1'b0;
    rd_m  = '0;
  endtask

  // One-cycle trigger pulse; returns cycles from acceptance to evaldone (-1 on timeout).
  task automatic drive_op(input logic p, input logic [WIDTH-1:0] d,
                          output int lat, output logic [WIDTH-1:0] rd, output logic extra);
    @(negedge clk);
    evalpush    = p;
    evalwrite   = d;
    evaltrigger = 1'b1;
    @(negedge clk);
    evaltrigger = 1'b0;
    evalpush    = 1'($urandom);
    evalwrite   = $urandom;
    lat   = -1;
    rd    = '0;
    extra = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (evaldone) begin
        lat = k;
        rd  = evalread;
        break;
      end
    end
    if (lat > 0) begin
      @(negedge clk);
      extra = evaldone;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    evaltrigger = 1'b0;
    evalpush = 1'b0;
    evalwrite = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (evaldone !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", evaldone); end
    checks++; if (depth !== '0) begin errors++; $display("FAIL reset_depth: got %0d want 0", depth); end
    checks++; if (evalread !== '0) begin errors++; $display("FAIL reset_read: got %h want 0", evalread); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_unf: got %b want 0", underflow); end
  endtask

  task automatic test_pop_empty();
    int elat, lat;
    logic [WIDTH-1:0] rd;
    logic extra;
    model_op(1'b0, '0, elat);
    drive_op(1'b0, $urandom, lat, rd, extra);
    checks++; if (lat !== elat) begin errors++; $display("FAIL pop_empty_lat: got %0d want %0d", lat, elat); end
    checks++; if (rd !== '0) begin errors++; $display("FAIL pop_empty_read: got %h want 0", rd); end
    checks++; if (depth !== '0) begin errors++; $display("FAIL pop_empty_depth: got %0d want 0", depth); end
    checks++; if (underflow !== exp_unf()) begin errors++; $display("FAIL pop_empty_unf: got %b want %b", underflow, exp_unf()); end
    checks++; if (overflow !== exp_ovf()) begin errors++; $display("FAIL pop_empty_ovf: got %b want %b", overflow, exp_ovf()); end
    checks++; if (extra !== 1'b0) begin errors++; $display("FAIL pop_empty_pulse: done wide got %b want 0", extra); end
  endtask

  task automatic test_lifo();
    logic             ops_p [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [WIDTH-1:0] ops_d [6] = '{32'h11, 32'h22, 32'h33, 32'h0, 32'h0, 32'h0};
    int elat, lat;
    logic [WIDTH-1:0] rd;
    logic extra;
    for (int i = 0; i < 6; i++) begin
      model_op(ops_p[i], ops_d[i], elat);
      drive_op(ops_p[i], ops_d[i], lat, rd, extra);
      checks++; if (lat !== elat) begin errors++; $display("FAIL lifo_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (rd !== rd_m) begin errors++; $display("FAIL lifo_read[%0d]: got %h want %h", i, rd, rd_m); end
      checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL lifo_depth[%0d]: got %0d want %0d", i, depth, stk.size()); end
      checks++; if (extra !== 1'b0) begin errors++; $display("FAIL lifo_pulse[%0d]: got %b want 0", i, extra); end
    end
  endtask

  task automatic test_overflow();
    int elat, lat;
    logic [WIDTH-1:0] rd;
    logic extra;
    for (int i = 1; i <= 9; i++) begin
      logic p = (i <= 5);
      model_op(p, WIDTH'(i), elat);
      drive_op(p, WIDTH'(i), lat, rd, extra);
      checks++; if (lat !== elat) begin errors++; $display("FAIL ovf_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (rd !== rd_m) begin errors++; $display("FAIL ovf_read[%0d]: got %h want %h", i, rd, rd_m); end
      checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL ovf_depth[%0d]: got %0d want %0d", i, depth, stk.size()); end
      checks++; if (overflow !== exp_ovf()) begin errors++; $display("FAIL ovf_flag[%0d]: got %b want %b", i, overflow, exp_ovf()); end
    end
  endtask

  task automatic test_hold();
    int elat, dones;
    logic [DW-1:0] d_before;
    d_before = depth;
    model_op(1'b1, 32'h7, elat);
    dones = 0;
    @(negedge clk);
    evalpush = 1'b1;
    evalwrite = 32'h7;
    evaltrigger = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (evaldone) dones++;
    end
    evaltrigger = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (evaldone) dones++;
    end
    checks++; if (dones !== 1) begin errors++; $display("FAIL hold_dones: got %0d want 1", dones); end
    checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL hold_depth: got %0d want %0d (was %0d)", depth, stk.size(), d_before); end
  endtask

  task automatic test_back_to_back();
    int elat, lat, gap;
    logic [WIDTH-1:0] rd, rd1, rd2, exp1, exp2;
    logic extra;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_op(1'b1, 32'hA5A5_0001, elat);
    drive_op(1'b1, 32'hA5A5_0001, lat, rd, extra);
    model_op(1'b1, 32'h5A5A_0002, elat);
    drive_op(1'b1, 32'h5A5A_0002, lat, rd, extra);
    model_op(1'b0, '0, elat);
    exp1 = rd_m;
    model_op(1'b0, '0, elat);
    exp2 = rd_m;
    @(negedge clk);
    evalpush = 1'b0;
    evaltrigger = 1'b1;
    @(negedge clk);
    evaltrigger = 1'b0;
    lat = -1;
    rd1 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (evaldone) begin
        lat = k;
        rd1 = evalread;
        break;
      end
    end
    evaltrigger = 1'b1;
    gap = -1;
    rd2 = '0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) evaltrigger = 1'b0;
      if (evaldone) begin
        gap = k;
        rd2 = evalread;
        break;
      end
    end
    checks++; if (lat !== 2) begin errors++; $display("FAIL b2b_lat: got %0d want 2", lat); end
    checks++; if (rd1 !== exp1) begin errors++; $display("FAIL b2b_read1: got %h want %h", rd1, exp1); end
    checks++; if (gap !== 3) begin errors++; $display("FAIL b2b_gap: got %0d want 3", gap); end
    checks++; if (rd2 !== exp2) begin errors++; $display("FAIL b2b_read2: got %h want %h", rd2, exp2); end
    checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL b2b_depth: got %0d want %0d", depth, stk.size()); end
  endtask

  task automatic test_random();
    int elat, lat;
    logic [WIDTH-1:0] rd, d;
    logic extra, p;
    for (int i = 0; i < 40; i++) begin
      p = ($urandom_range(0, 99) < 55);
      d = $urandom;
      model_op(p, d, elat);
      drive_op(p, d, lat, rd, extra);
      checks++; if (lat !== elat) begin errors++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", i, lat, elat); end
      checks++; if (rd !== rd_m) begin errors++; $display("FAIL rnd_read[%0d]: got %h want %h", i, rd, rd_m); end
      checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL rnd_depth[%0d]: got %0d want %0d", i, depth, stk.size()); end
      checks++; if (overflow !== exp_ovf()) begin errors++; $display("FAIL rnd_ovf[%0d]: got %b want %b", i, overflow, exp_ovf()); end
      checks++; if (underflow !== exp_unf()) begin errors++; $display("FAIL rnd_unf[%0d]: got %b want %b", i, underflow, exp_unf()); end
      checks++; if (extra !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d]: got %b want 0", i, extra); end
    end
  endtask

  task automatic test_reset_midop();
    int elat, lat, dones;
    logic [WIDTH-1:0] rd;
    logic extra;
    model_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_op(1'b1, 32'hCAFE_0001, elat);
    drive_op(1'b1, 32'hCAFE_0001, lat, rd, extra);
    model_op(1'b1, 32'hCAFE_0002, elat);
    drive_op(1'b1, 32'hCAFE_0002, lat, rd, extra);
    checks++; if (depth !== DW'(2)) begin errors++; $display("FAIL midrst_pre_depth: got %0d want 2", depth); end
    @(negedge clk);
    evalpush = 1'b0;
    evaltrigger = 1'b1;
    @(negedge clk);
    evaltrigger = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (evaldone) dones++;
    end
    checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_dones: got %0d want 0", dones); end
    checks++; if (depth !== DW'(stk.size())) begin errors++; $display("FAIL midrst_depth: got %0d want %0d", depth, stk.size()); end
    checks++; if (evalread !== rd_m) begin errors++; $display("FAIL midrst_read: got %h want %h", evalread, rd_m); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL midrst_ovf: got %b want 0", overflow); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL midrst_unf: got %b want 0", underflow); end
  endtask

  initial begin
    rst = 1'b1;
    evalpush = 1'b0;
    evaltrigger = 1'b0;
    evalwrite = '0;
    test_reset();
    test_pop_empty();
    test_lifo();
    test_overflow();
    test_hold();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
